serial_subtractor: RTL

Bit-serial unsigned subtractor computing a - b, LSB first, one bit per clock through a single 1-bit full-subtractor cell. It is the inverse-direction counterpart of the team's ripple full-adder blocks. It trades area for latency and sits behind a valid/ready handshake on both sides, so it can be dropped into datapaths that already use the adder family.

---
 rtl/serial_subtractor_pkg.sv | 19 +
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor_full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 89 ++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and sizing helpers for the serial arithmetic blocks
package serial_arith_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      RUN  = S_RUN,
      DONE = S_DONE
   } state_e;

   // Bit counter width: enough to count 0..width-1.
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for the serial subtractor
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, borrow
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, borrow
   );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - 1-bit full subtractor cell, counterpart of the 1-bit full adder
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   // Borrow out when b (plus incoming borrow) exceeds a in this bit position.
   always_comb begin
      diff = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned a - b, LSB first, behind valid/ready handshakes
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] diff_q;
   logic [CW-1:0]    cnt_q;
   logic             br_q;
   logic             borrow_q;
   logic             out_valid_q;

   logic             cell_diff;
   logic             cell_bout;

   full_subtractor u_cell (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (br_q),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   // Control FSM and datapath: accept operands, shift one bit per clock, hold result until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         diff_q      <= '0;
         cnt_q       <= '0;
         br_q        <= 1'b0;
         borrow_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh_q  <= bus.a;
                  b_sh_q  <= bus.b;
                  br_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_sh_q <= a_sh_q >> 1;
               b_sh_q <= b_sh_q >> 1;
               diff_q <= {cell_diff, diff_q[WIDTH-1:1]};
               br_q   <= cell_bout;
               cnt_q  <= cnt_q + 1'b1;
               // The edge that processes the MSB also publishes the final borrow.
               if (cnt_q == LAST) begin
                  borrow_q    <= cell_bout;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.diff      = diff_q;
   assign bus.borrow    = borrow_q;

endmodule
